// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache with one 32-bit word per line.
// It sits between the IF stage and a byte-wide memory arbiter. A hit returns
// the word combinationally in the same cycle. A miss refills the word as four
// little-endian bytes, then the request completes through the hit path.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   rdy           global ready; 0 freezes all state and drops mem_req_o
//   flush_i       pipeline flush; aborts an in-flight refill
//   req_i, pc_i   fetch request and byte address (pc_i[1:0] ignored)
//   inst_o        fetched instruction, 0 unless done_o
//   done_o        instruction for pc_i is available this cycle
//   mem_req_o     byte read request to the arbiter
//   mem_addr_o    byte address of the current request
//   mem_rvalid_i  byte for mem_addr_o returned this cycle
//   mem_rdata_i   returned byte
module icache_fetch #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush_i,
  input  logic        req_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic        done_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [7:0]  mem_rdata_i
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  logic [31:0] fill_addr;
  logic [1:0]  cnt;
  logic [23:0] fill_buf;   // bytes 0..2; byte 3 goes straight from mem_rdata_i

  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TAG_W-1:0]      tag, fill_tag;
  logic miss, take, line_wr;
  logic unused_pc;

  assign idx       = pc_i[INDEX_BITS+1:2];
  assign tag       = pc_i[ADDR_BITS-1:INDEX_BITS+2];
  assign fill_idx  = fill_addr[INDEX_BITS+1:2];
  assign fill_tag  = fill_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign unused_pc = ^pc_i[1:0];

  always_comb begin
    state_nxt  = state;
    miss       = 1'b0;
    take       = 1'b0;
    line_wr    = 1'b0;
    done_o     = 1'b0;
    inst_o     = '0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (rdy && req_i && !flush_i) begin
            if (valid[idx] && (tag_arr[idx] == tag)) begin
              done_o = 1'b1;
              inst_o = data_arr[idx];
            end else begin
              miss      = 1'b1;
              state_nxt = FILL;
            end
          end
        end
        FILL: begin
          // Request stays up in a flush cycle; it falls once back in IDLE.
          mem_req_o  = rdy;
          mem_addr_o = fill_addr + {30'd0, cnt};
          if (rdy) begin
            if (flush_i) begin
              state_nxt = IDLE;   // flush beats a last-byte return
            end else if (mem_rvalid_i) begin
              take = 1'b1;
              if (cnt == 2'd3) begin
                line_wr   = 1'b1;
                state_nxt = IDLE;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      cnt       <= '0;
      fill_addr <= '0;
      fill_buf  <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      if (miss) begin
        fill_addr <= {pc_i[31:2], 2'b00};
        cnt       <= '0;
      end
      if (take) begin
        case (cnt)
          2'd0:    fill_buf[7:0]   <= mem_rdata_i;
          2'd1:    fill_buf[15:8]  <= mem_rdata_i;
          2'd2:    fill_buf[23:16] <= mem_rdata_i;
          default: ;
        endcase
        if (cnt != 2'd3) cnt <= cnt + 2'd1;
      end
      if (line_wr) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (line_wr) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= {mem_rdata_i, fill_buf};
    end
  end
endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: a line-level cache model (per-index valid/tag/word
// plus a queue of bytes collected for the pending refill) checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_icache_fetch;
  logic        clk = 1'b0;
  logic        rst, rdy, flush_i, req_i;
  logic [31:0] pc_i;
  logic [31:0] inst_o, mem_addr_o;
  logic        done_o, mem_req_o;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;

  always #5 clk = ~clk;

  icache_fetch #(.INDEX_BITS(7), .ADDR_BITS(18)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i), .req_i(req_i),
    .pc_i(pc_i), .inst_o(inst_o), .done_o(done_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [1024];
  logic       arb_en;

  // model
  bit          mv    [128];
  logic [8:0]  mtag  [128];
  logic [31:0] mdata [128];
  bit          mfill;
  logic [31:0] mfaddr;
  logic [7:0]  mq [$];

  // last sampled DUT outputs
  logic        s_done, s_req;
  logic [31:0] s_inst, s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    logic [6:0]  i;
    logic [8:0]  t;
    logic        hit, e_done, e_req;
    logic [31:0] e_inst, e_addr;
    #1;
    mem_rvalid_i = arb_en && mem_req_o;
    mem_rdata_i  = mem_rvalid_i ? mem[mem_addr_o[9:0]] : 8'h00;
    #1;
    i = pc_i[8:2];
    t = pc_i[17:9];
    hit    = !rst && !mfill && rdy && req_i && !flush_i && mv[i] && (mtag[i] == t);
    e_done = hit;
    e_inst = hit ? mdata[i] : 32'h0;
    e_req  = !rst && mfill && rdy;
    e_addr = (!rst && mfill) ? mfaddr + 32'(mq.size()) : 32'h0;
    s_done = done_o; s_req = mem_req_o; s_inst = inst_o; s_addr = mem_addr_o;
    chk("m_done", {31'd0, s_done}, {31'd0, e_done});
    chk("m_inst", s_inst, e_inst);
    chk("m_req",  {31'd0, s_req}, {31'd0, e_req});
    chk("m_addr", s_addr, e_addr);
    @(posedge clk);
    if (rst) begin
      foreach (mv[k]) mv[k] = 1'b0;
      mfill = 1'b0;
      mq.delete();
    end else if (rdy) begin
      if (!mfill) begin
        if (req_i && !flush_i && !hit) begin
          mfill  = 1'b1;
          mfaddr = {pc_i[31:2], 2'b00};
          mq.delete();
        end
      end else if (flush_i) begin
        mfill = 1'b0;
      end else if (mem_rvalid_i) begin
        mq.push_back(mem_rdata_i);
        if (mq.size() == 4) begin
          mv[mfaddr[8:2]]    = 1'b1;
          mtag[mfaddr[8:2]]  = mfaddr[17:9];
          mdata[mfaddr[8:2]] = {mq[3], mq[2], mq[1], mq[0]};
          mfill = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic run_done(input string name, input int maxc);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!s_done && n < maxc);
    chk(name, {31'd0, s_done}, 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a) ^ 8'hA5;
    mem[10'h104] = 8'h13; mem[10'h105] = 8'h05;
    mem[10'h106] = 8'h10; mem[10'h107] = 8'h00;
    mfill = 1'b0;
    rst = 1'b1; rdy = 1'b1; flush_i = 1'b0; req_i = 1'b0; pc_i = 32'h0;
    arb_en = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 8'h00;

    // reset
    cycle();
    chk("rst_done", {31'd0, s_done}, 32'd0);
    chk("rst_req",  {31'd0, s_req},  32'd0);
    chk("rst_addr", s_addr, 32'd0);
    chk("rst_inst", s_inst, 32'd0);
    cycle();
    rst = 1'b0;
    cycle();

    // cold miss at 0x104
    req_i = 1'b1; pc_i = 32'h0000_0104;
    cycle();
    chk("cold_miss_done", {31'd0, s_done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("cold_req",  {31'd0, s_req}, 32'd1);
      chk("cold_addr", s_addr, 32'h104 + 32'(k));
    end
    cycle();
    chk("cold_done_t5", {31'd0, s_done}, 32'd1);
    chk("cold_inst", s_inst, 32'h0010_0513);

    // hit, then alias with ignored high/low bits
    cycle();
    chk("hit_done", {31'd0, s_done}, 32'd1);
    chk("hit_inst", s_inst, 32'h0010_0513);
    chk("hit_req",  {31'd0, s_req}, 32'd0);
    pc_i = 32'hFFFC_0105;
    cycle();
    chk("alias_done", {31'd0, s_done}, 32'd1);

    // conflict on index 0x41
    pc_i = 32'h0000_0304;
    cycle();
    chk("conf_miss", {31'd0, s_done}, 32'd0);
    run_done("conf_fill", 10);
    chk("conf_inst", s_inst, 32'hA2A3_A0A1);
    pc_i = 32'h0000_0104;
    cycle();
    chk("conf_evict", {31'd0, s_done}, 32'd0);
    run_done("conf_refill", 10);
    chk("conf_inst2", s_inst, 32'h0010_0513);

    // flush mid-fill
    pc_i = 32'h0000_0200;
    cycle(); cycle(); cycle();
    flush_i = 1'b1;
    cycle();
    chk("fl_req_hold", {31'd0, s_req}, 32'd1);
    chk("fl_done",     {31'd0, s_done}, 32'd0);
    flush_i = 1'b0; req_i = 1'b0;
    cycle();
    chk("fl_req_drop", {31'd0, s_req}, 32'd0);
    req_i = 1'b1;
    cycle();
    chk("fl_remiss", {31'd0, s_done}, 32'd0);
    cycle();
    chk("fl_byte0", s_addr, 32'h200);
    run_done("fl_fill", 10);
    chk("fl_inst", s_inst, 32'hA6A7_A4A5);

    // stall at cnt=2
    pc_i = 32'h0000_0048;
    cycle(); cycle(); cycle();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_req", {31'd0, s_req}, 32'd0);
    end
    rdy = 1'b1;
    cycle();
    chk("stall_resume_addr", s_addr, 32'h4A);
    run_done("stall_fill", 10);
    chk("stall_inst", s_inst, 32'hEEEF_ECED);

    // reset mid-fill invalidates everything
    pc_i = 32'h0000_00A0;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rmf_miss", {31'd0, s_done}, 32'd0);
    run_done("rmf_fill", 10);
    pc_i = 32'h0000_0104;
    cycle();
    chk("rmf_inval", {31'd0, s_done}, 32'd0);
    run_done("rmf_refill", 10);

    // flush together with the last byte
    pc_i = 32'h0000_00C0;
    cycle(); cycle(); cycle(); cycle();
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    cycle();
    chk("fl3_miss", {31'd0, s_done}, 32'd0);
    run_done("fl3_fill", 10);
    chk("fl3_inst", s_inst, 32'h6667_6465);

    // flush in IDLE does not start a miss
    pc_i = 32'h0000_01F0; flush_i = 1'b1;
    cycle();
    chk("fli_done", {31'd0, s_done}, 32'd0);
    flush_i = 1'b0; req_i = 1'b0;
    cycle();
    chk("fli_noreq", {31'd0, s_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, single-word-line instruction cache between the instruction-fetch stage and the byte-wide memory arbiter.
- Answers the IF stage's fetch request (pc, request) with a 32-bit instruction and a done flag.
- A hit completes in the same cycle. A miss runs a 4-byte little-endian refill over the 8-bit memory port, then completes.
- Supports pipeline flush (aborts an in-flight refill) and a global ready/freeze input.

Parameters:
- INDEX_BITS, 7, log2 of line count (128 lines, one 32-bit word each).
- ADDR_BITS, 18, significant byte-address bits. Tag width = ADDR_BITS-INDEX_BITS-2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global ready. When 0, all state is frozen.
- flush_i  input  1  pipeline flush (branch redirect). Aborts any refill.
- req_i  input  1  fetch request from the IF stage.
- pc_i  input  32  fetch address. Bits [1:0] are ignored.
- inst_o  output  32  instruction. Valid only while done_o=1, otherwise 0.
- done_o  output  1  instruction for pc_i is available this cycle.
- mem_req_o  output  1  byte read request to the arbiter.
- mem_addr_o  output  32  byte address of the current request.
- mem_rvalid_i  input  1  byte returned this cycle for mem_addr_o.
- mem_rdata_i  input  8  returned byte.

Behaviour:
- Address split: index = pc_i[INDEX_BITS+1:2]; tag = pc_i[ADDR_BITS-1:INDEX_BITS+2]. Bits above ADDR_BITS are ignored.
- Storage: valid[2^INDEX_BITS], tag array, data array. Arrays are read combinationally.
- Reset: all valid bits cleared; state=IDLE; byte counter=0. Outputs: inst_o=0, done_o=0, mem_req_o=0, mem_addr_o=0. Data and tag contents are don't-care.
- Hit condition: rst=0, rdy=1, req_i=1, flush_i=0, valid[index], and tag match. On a hit, done_o=1 and inst_o=data[index] in the same cycle (combinational). Hits are served in IDLE only.
- States: IDLE, FILL.
- IDLE, on a miss (req_i=1, rdy=1, flush_i=0, not a hit):
  - latch fill_addr = {pc_i[31:2],2'b00};
  - cnt=0;
  - go to FILL at the next edge.
  - done_o=0 during the miss cycle.
- FILL outputs: mem_req_o=rdy; mem_addr_o=fill_addr+cnt; done_o=0 regardless of pc_i.
- FILL, on mem_rvalid_i=1 (with rdy=1):
  - store mem_rdata_i into buffer byte lane cnt (byte 0 = bits [7:0]);
  - if cnt<3, cnt increments;
  - if cnt==3, write the line (data = assembled word with the last byte in [31:24], tag, valid=1) at fill_addr's index and return to IDLE.
- The refill always completes for the latched fill_addr, even if req_i drops or pc_i changes (no flush). Afterwards pc_i is re-evaluated in IDLE.
- Miss latency with back-to-back rvalid:
  - miss detected at cycle t;
  - FILL occupies t+1..t+4;
  - done_o=1 at t+5 via the hit path.
- flush_i=1:
  - done_o forced 0 that cycle;
  - in FILL, go to IDLE at the next edge with no line write and the partial buffer discarded;
  - mem_req_o stays high (when rdy=1) in the flush cycle and drops to 0 from the next cycle;
  - flush_i together with rvalid at cnt==3: flush wins, line not written;
  - flush_i in IDLE: no state change; a miss is not started that cycle.
- rdy=0: no register updates and mem_req_o=0. mem_rvalid_i is ignored; the arbiter must not return data while mem_req_o=0. done_o=0.
- rst mid-FILL: IDLE next edge, all lines invalidated, partial fill discarded.
- Line overwrite: a fill into an occupied index replaces the tag and data unconditionally.
- Only one outstanding byte request. No writes from the data path (no self-modifying code support).

Test Plan:
- Cold miss: reset, req_i=1, pc_i=0x0000_0104; the arbiter returns 0x13,0x05,0x10,0x00 on consecutive cycles with rvalid. Required:
  - mem_addr_o steps 0x104..0x107;
  - done_o=1 at t+5 with inst_o=0x0010_0513.
- Hit: after the above, pc_i=0x104 -> done_o=1 in the same cycle, inst_o=0x0010_0513, mem_req_o=0.
- Conflict: fill 0x104, then fetch 0x304 (same index, different tag) -> miss and refill. A later fetch of 0x104 misses again.
- Flush mid-fill: miss at 0x200, two bytes returned, then flush_i=1. Required:
  - IDLE next cycle and mem_req_o=0;
  - a subsequent fetch of 0x200 misses and refills from byte 0.
- Stall: rdy=0 for 3 cycles during FILL at cnt=2. Required:
  - mem_req_o=0 and cnt holds at 2;
  - on resume, mem_addr_o=fill_addr+2 and the fill completes correctly.
- Reset mid-fill and simultaneous flush with the last byte: both leave the line invalid; the next fetch of that pc misses.
